// File: rtl/lap_pkg.sv
// Shared constants, state type and slot-mapping helper for the lap record store.
package lap_pkg;
    localparam int DEPTH_MAX  = 16;
    localparam int IDX_W      = 5;
    localparam int PTR_W      = 4;
    localparam int SUM_W      = IDX_W + 1;
    localparam int TIME_W_DEF = 24;

    typedef enum logic [1:0] {EMPTY, LIVE, BROWSE} lap_state_t;

    // Record n (1-based) lives at (base + n - 1) mod depth.
    function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base,
                                                  input logic [IDX_W-1:0] idx,
                                                  input int depth);
        logic [IDX_W-1:0] off;
        logic [SUM_W-1:0] sum;
        off = idx - IDX_W'(1);
        sum = SUM_W'(base) + SUM_W'(off);
        if (sum >= SUM_W'(depth)) begin
            sum = sum - SUM_W'(depth);
        end
        return sum[PTR_W-1:0];
    endfunction
endpackage

// File: rtl/lap_recorder_if.sv
// Control/data bundle between the stopwatch front end and the lap record store.
interface lap_recorder_if #(parameter int TIME_W = lap_pkg::TIME_W_DEF);
    import lap_pkg::*;

    logic              sw_mode;
    logic [TIME_W-1:0] time_in;
    logic              lap_pulse;
    logic              next_pulse;
    logic              prev_pulse;
    logic              exit_pulse;
    logic              clr_pulse;
    logic [IDX_W-1:0]  rec_idx;
    logic              idx_disp_en;
    logic [TIME_W-1:0] rec_time;
    logic [IDX_W-1:0]  rec_count;
    logic              full;

    modport master (
        output sw_mode, time_in, lap_pulse, next_pulse, prev_pulse, exit_pulse, clr_pulse,
        input  rec_idx, idx_disp_en, rec_time, rec_count, full
    );

    modport slave (
        input  sw_mode, time_in, lap_pulse, next_pulse, prev_pulse, exit_pulse, clr_pulse,
        output rec_idx, idx_disp_en, rec_time, rec_count, full
    );
endinterface

// File: rtl/lap_mem.sv
// Lap time register file: one synchronous write port, one asynchronous read port.
module lap_mem import lap_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [TIME_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [TIME_W-1:0] rd_data
);
    logic [DEPTH-1:0][TIME_W-1:0] entries;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [TIME_W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (we && (wr_addr == PTR_W'(gi))) begin
                    data_reg <= wr_data;
                end
            end
            assign entries[gi] = data_reg;
        end
    endgenerate

    assign rd_data = entries[rd_addr];
endmodule

// File: rtl/lap_recorder.sv
// Stopwatch lap store with browse FSM. Define LAP_OVERWRITE_EN to make the
// buffer circular (a lap when full replaces the oldest entry).
module lap_recorder import lap_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    lap_recorder_if.slave bus
);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    lap_state_t        state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [IDX_W-1:0]  rec_count_reg, rec_count_next;
    logic [IDX_W-1:0]  rec_idx_reg, rec_idx_next;
    logic              disp_en_reg;
    logic              full_reg;
    logic              lap_we;
    logic [PTR_W-1:0]  base_ptr;
    logic [PTR_W-1:0]  rd_slot;
    logic [TIME_W-1:0] rd_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef LAP_OVERWRITE_EN
    logic [PTR_W-1:0] oldest_ptr_reg, oldest_ptr_next;

    // When full, the write slot coincides with the oldest slot, so both advance together.
    assign lap_we = bus.sw_mode && bus.lap_pulse && !bus.clr_pulse;

    always_comb begin
        oldest_ptr_next = oldest_ptr_reg;
        if (bus.clr_pulse) begin
            oldest_ptr_next = '0;
        end else if (lap_we && full_reg) begin
            oldest_ptr_next = ptr_inc(oldest_ptr_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oldest_ptr_reg <= '0;
        end else begin
            oldest_ptr_reg <= oldest_ptr_next;
        end
    end

    assign base_ptr = oldest_ptr_reg;
`else
    assign lap_we   = bus.sw_mode && bus.lap_pulse && !bus.clr_pulse && !full_reg;
    assign base_ptr = '0;
`endif

    always_comb begin
        state_next     = state_reg;
        rec_idx_next   = rec_idx_reg;
        wr_ptr_next    = wr_ptr_reg;
        rec_count_next = rec_count_reg;

        if (lap_we) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (!full_reg) begin
                rec_count_next = rec_count_reg + IDX_W'(1);
            end
        end

        if (bus.clr_pulse) begin
            state_next     = EMPTY;
            rec_idx_next   = '0;
            wr_ptr_next    = '0;
            rec_count_next = '0;
        end else begin
            // Browse moves and wrap bounds use the pre-write count.
            case (state_reg)
                EMPTY: begin
                    if (lap_we) begin
                        state_next = LIVE;
                    end
                end
                LIVE: begin
                    if (bus.sw_mode && !bus.exit_pulse) begin
                        if (bus.next_pulse) begin
                            state_next   = BROWSE;
                            rec_idx_next = IDX_W'(1);
                        end else if (bus.prev_pulse) begin
                            state_next   = BROWSE;
                            rec_idx_next = rec_count_reg;
                        end
                    end
                end
                BROWSE: begin
                    if (bus.exit_pulse || !bus.sw_mode) begin
                        state_next   = LIVE;
                        rec_idx_next = '0;
                    end else if (bus.next_pulse && !bus.prev_pulse) begin
                        rec_idx_next = (rec_idx_reg == rec_count_reg) ? IDX_W'(1)
                                                                      : rec_idx_reg + IDX_W'(1);
                    end else if (bus.prev_pulse && !bus.next_pulse) begin
                        rec_idx_next = (rec_idx_reg == IDX_W'(1)) ? rec_count_reg
                                                                  : rec_idx_reg - IDX_W'(1);
                    end
                end
                default: begin
                    state_next   = EMPTY;
                    rec_idx_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            wr_ptr_reg    <= '0;
            rec_count_reg <= '0;
            rec_idx_reg   <= '0;
            disp_en_reg   <= 1'b0;
            full_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rec_count_reg <= rec_count_next;
            rec_idx_reg   <= rec_idx_next;
            disp_en_reg   <= (state_next == BROWSE);
            full_reg      <= (rec_count_next == DEPTH_IDX);
        end
    end

    assign rd_slot = slot_of(base_ptr, rec_idx_reg, DEPTH);

    lap_mem #(
        .DEPTH  (DEPTH),
        .TIME_W (TIME_W)
    ) u_mem (
        .clk     (clk),
        .we      (lap_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (bus.time_in),
        .rd_addr (rd_slot),
        .rd_data (rd_data)
    );

    assign bus.rec_idx     = rec_idx_reg;
    assign bus.idx_disp_en = disp_en_reg;
    assign bus.rec_time    = (rec_idx_reg != '0) ? rd_data : '0;
    assign bus.rec_count   = rec_count_reg;
    assign bus.full        = full_reg;
endmodule
